// File: rtl/ioctl_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ioctl_loader_pkg                                                           |
// | Shared types and helpers for the HPS download-to-boot-ROM loader.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ioctl_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FILL = 2'd2,
      HOLD = 2'd3
   } loader_state_t;

   localparam logic [7:0] c_DEFAULT_FILL_BYTE = 8'h00;

   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ioctl_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ioctl_rom_loader                                                           |
// | Copies the hps_io download stream into the CPU boot memory, optionally     |
// | zero-fills the tail, and holds the CPU in reset until the copy settles.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ioctl_rom_loader
   import ioctl_loader_pkg::*;
#(
   parameter int         ADDR_W      = 12,
   parameter bit         FILL_EN     = 1'b1,
   parameter logic [7:0] FILL_BYTE   = c_DEFAULT_FILL_BYTE,
   parameter int         HOLD_CYCLES = 256
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [26:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              cpu_reset,
   output logic              busy,
   output logic [ADDR_W:0]   load_len,
   output logic              overflow,
   output logic              done
);

   localparam int unsigned           c_DEPTH     = depth_of(ADDR_W);
   localparam int                    c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [26:0]           c_DEPTH_27  = 27'(c_DEPTH);
   localparam logic [ADDR_W:0]       c_DEPTH_LEN = (ADDR_W + 1)'(c_DEPTH);
   localparam logic [ADDR_W:0]       c_LEN_ONE   = (ADDR_W + 1)'(1);
   localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [c_HOLD_W-1:0]   c_HOLD_ONE  = c_HOLD_W'(1);

   loader_state_t        r_state;
   logic [c_HOLD_W-1:0]  r_hold_cnt;
   logic [ADDR_W:0]      r_fill_ptr;
   logic                 r_pending_done;
   logic                 r_mem_we;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [7:0]           r_mem_data;
   logic                 r_cpu_reset;
   logic                 r_busy;
   logic [ADDR_W:0]      r_load_len;
   logic                 r_overflow;
   logic                 r_done;

   logic                 w_in_range;
   logic                 w_accept;
   logic                 w_start;
   logic [ADDR_W:0]      w_addr_p1;
   logic [ADDR_W:0]      w_len_next;

   // The full 27-bit compare keeps aliased high addresses out of memory.
   always_comb begin
      w_in_range = (ioctl_addr < c_DEPTH_27);
      w_accept   = ioctl_wr && w_in_range;
      w_start    = ioctl_download && (r_state != LOAD);
      w_addr_p1  = {1'b0, ioctl_addr[ADDR_W-1:0]} + c_LEN_ONE;
      w_len_next = r_load_len;
      if (w_accept && (w_addr_p1 > r_load_len)) begin
         w_len_next = w_addr_p1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state        <= HOLD;
         r_hold_cnt     <= '0;
         r_fill_ptr     <= '0;
         r_pending_done <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_data     <= '0;
         r_cpu_reset    <= 1'b1;
         r_busy         <= 1'b0;
         r_load_len     <= '0;
         r_overflow     <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;
         if (w_start) begin
            // A new download always wins, discarding any fill or hold in flight.
            r_state        <= LOAD;
            r_cpu_reset    <= 1'b1;
            r_busy         <= 1'b1;
            r_load_len     <= '0;
            r_overflow     <= 1'b0;
            r_hold_cnt     <= '0;
            r_pending_done <= 1'b1;
         end else begin
            case (r_state)
               LOAD: begin
                  if (w_accept) begin
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= ioctl_addr[ADDR_W-1:0];
                     r_mem_data <= ioctl_dout;
                  end
                  if (ioctl_wr && !w_in_range) begin
                     r_overflow <= 1'b1;
                  end
                  r_load_len <= w_len_next;
                  if (!ioctl_download) begin
                     if (FILL_EN && (w_len_next < c_DEPTH_LEN)) begin
                        r_state    <= FILL;
                        r_fill_ptr <= w_len_next;
                     end else begin
                        r_state    <= HOLD;
                        r_busy     <= 1'b0;
                        r_hold_cnt <= '0;
                     end
                  end
               end
               FILL: begin
                  if (r_fill_ptr < c_DEPTH_LEN) begin
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= r_fill_ptr[ADDR_W-1:0];
                     r_mem_data <= FILL_BYTE;
                     r_fill_ptr <= r_fill_ptr + c_LEN_ONE;
                  end else begin
                     r_state    <= HOLD;
                     r_busy     <= 1'b0;
                     r_hold_cnt <= '0;
                  end
               end
               HOLD: begin
                  if (r_hold_cnt == c_HOLD_LAST) begin
                     r_state        <= IDLE;
                     r_cpu_reset    <= 1'b0;
                     r_done         <= r_pending_done;
                     r_pending_done <= 1'b0;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_data  = r_mem_data;
   assign cpu_reset = r_cpu_reset;
   assign busy      = r_busy;
   assign load_len  = r_load_len;
   assign overflow  = r_overflow;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ioctl_rom_loader                                                        |
// | Scoreboard bench: two loaders (fill on / fill off) share one stimulus.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ioctl_rom_loader;

   localparam int c_AW    = 12;
   localparam int c_DEPTH = 4096;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [26:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;

   logic            f_mem_we, f_cpu_reset, f_busy, f_overflow, f_done;
   logic [c_AW-1:0] f_mem_addr;
   logic [7:0]      f_mem_data;
   logic [c_AW:0]   f_load_len;
   logic            n_mem_we, n_cpu_reset, n_busy, n_overflow, n_done;
   logic [c_AW-1:0] n_mem_addr;
   logic [7:0]      n_mem_data;
   logic [c_AW:0]   n_load_len;

   ioctl_rom_loader #(.ADDR_W(c_AW), .FILL_EN(1'b1), .FILL_BYTE(8'h00), .HOLD_CYCLES(256)) u_fill (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
      .mem_data(f_mem_data), .cpu_reset(f_cpu_reset), .busy(f_busy), .load_len(f_load_len),
      .overflow(f_overflow), .done(f_done));

   ioctl_rom_loader #(.ADDR_W(c_AW), .FILL_EN(1'b0), .FILL_BYTE(8'h00), .HOLD_CYCLES(256)) u_nofill (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
      .mem_data(n_mem_data), .cpu_reset(n_cpu_reset), .busy(n_busy), .load_len(n_load_len),
      .overflow(n_overflow), .done(n_done));

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct {
      int a;
      int d;
      bit fill;
   } wr_t;

   wr_t q0[$];
   wr_t q1[$];
   int  exp_done[2];
   int  last_we[2];
   int  t_fall = 0;
   bit  fill0 = 1'b0;
   int  n_checks = 0;
   int  n_fail = 0;
   int  sa[$];
   int  sd[$];

   task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic mon(input int k, input logic we, input logic [c_AW-1:0] a, input logic [7:0] d,
                      input logic bsy, input logic cr, input logic dn);
      wr_t e;
      int  sz;
      sz = (k == 0) ? q0.size() : q1.size();
      if (we === 1'b1) begin
         if (sz == 0) begin
            chk(1'b0, $sformatf("unexpected_write[%0d]", k), {20'd0, a, d}, 0);
         end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk((int'(a) == e.a) && (int'(d) == e.d), $sformatf("write_addr_data[%0d]", k),
                {20'd0, a, d}, (e.a << 8) | e.d);
            if (e.fill) chk(bsy && cr, "busy_during_fill", {bsy, cr}, 2'b11);
            last_we[k] = cyc;
         end
      end
      if (dn === 1'b1) begin
         if (exp_done[k] == 0) begin
            chk(1'b0, $sformatf("unexpected_done[%0d]", k), 1, 0);
         end else begin
            exp_done[k]--;
            chk(cr == 1'b0, $sformatf("cpu_reset_falls_with_done[%0d]", k), cr, 0);
            if (k == 0 && fill0) chk(cyc - last_we[0] == 257, "done_after_fill", cyc - last_we[0], 257);
            else chk(cyc - t_fall == 256, $sformatf("done_after_load[%0d]", k), cyc - t_fall, 256);
         end
      end
   endtask

   always @(negedge clk_sys) begin
      mon(0, f_mem_we, f_mem_addr, f_mem_data, f_busy, f_cpu_reset, f_done);
      mon(1, n_mem_we, n_mem_addr, n_mem_data, n_busy, n_cpu_reset, n_done);
   end

   // Reset is already high on entry; checks reset values, then the power-on hold length.
   task automatic power_on();
      int n0, n1;
      repeat (3) @(negedge clk_sys);
      chk(f_cpu_reset && !f_busy && !f_mem_we && f_load_len == 0 && !f_overflow && !f_done,
          "reset_state_fill", {f_cpu_reset, f_busy, f_mem_we, f_overflow, f_done}, 5'b10000);
      chk(n_cpu_reset && !n_busy && !n_mem_we && n_load_len == 0 && !n_overflow && !n_done,
          "reset_state_nofill", {n_cpu_reset, n_busy, n_mem_we, n_overflow, n_done}, 5'b10000);
      reset = 1'b0;
      n0 = -1;
      n1 = -1;
      for (int i = 1; i <= 600; i++) begin
         @(posedge clk_sys);
         #1;
         if (n0 < 0 && !f_cpu_reset) n0 = i;
         if (n1 < 0 && !n_cpu_reset) n1 = i;
         if (n0 >= 0 && n1 >= 0) break;
      end
      chk(n0 == 256, "power_on_hold_fill", n0, 256);
      chk(n1 == 256, "power_on_hold_nofill", n1, 256);
   endtask

   task automatic note_fall(input int len, input int mode, input bit nf_done);
      t_fall = cyc + 1;
      fill0  = (len < c_DEPTH);
      for (int a = len; a < c_DEPTH; a++) q0.push_back('{a, 0, 1'b1});
      if (mode == 0) exp_done[0]++;
      if (nf_done) exp_done[1]++;
   endtask

   // mode 0: run to completion; 1: re-download when fill reaches 'at'; 2: reset there.
   task automatic run_seq(input int mode, input int at, input bit nf_done, input bit last_on_fall,
                          input bit fixed_gap);
      int len, n, gap;
      bit ovf;
      len = 0;
      ovf = 1'b0;
      if (!ioctl_download) begin
         @(negedge clk_sys);
         ioctl_download = 1'b1;
      end
      @(negedge clk_sys);
      chk(f_load_len == 0 && !f_overflow && n_load_len == 0 && !n_overflow, "start_clears_len_ovf",
          {f_load_len, f_overflow}, 0);
      chk(f_busy && n_busy && f_cpu_reset && n_cpu_reset, "busy_in_load", {f_busy, n_busy}, 2'b11);
      for (int i = 0; i < sa.size(); i++) begin
         gap = fixed_gap ? 3 : $urandom_range(0, 3);
         repeat (gap) @(negedge clk_sys);
         ioctl_wr   = 1'b1;
         ioctl_addr = 27'(sa[i]);
         ioctl_dout = 8'(sd[i]);
         if (sa[i] < c_DEPTH) begin
            q0.push_back('{sa[i], sd[i], 1'b0});
            q1.push_back('{sa[i], sd[i], 1'b0});
            if (sa[i] + 1 > len) len = sa[i] + 1;
         end else begin
            ovf = 1'b1;
         end
         if (last_on_fall && i == sa.size() - 1) begin
            ioctl_download = 1'b0;
            note_fall(len, mode, nf_done);
         end
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
      end
      if (!last_on_fall) begin
         @(negedge clk_sys);
         ioctl_download = 1'b0;
         note_fall(len, mode, nf_done);
      end
      if (mode == 0) begin
         n = 0;
         while ((exp_done[0] != 0 || exp_done[1] != 0) && n < 6000) begin
            @(negedge clk_sys);
            #1;
            n++;
         end
         chk(n < 6000, "done_within_budget", n, 6000);
         chk(f_load_len == len && n_load_len == len, "load_len", f_load_len, len);
         chk(f_overflow == ovf && n_overflow == ovf, "overflow", {f_overflow, n_overflow}, {ovf, ovf});
         chk(q0.size() == 0 && q1.size() == 0, "all_writes_seen", q0.size() + q1.size(), 0);
      end else begin
         n = 0;
         do begin
            @(negedge clk_sys);
            #1;
            n++;
         end while (!(f_mem_we && int'(f_mem_addr) == at) && n < 6000);
         chk(n < 6000, "fill_reaches_abort_point", n, 6000);
         chk(f_load_len == len && f_overflow == ovf, "len_ovf_before_abort", {f_load_len, f_overflow},
             {len[c_AW:0], ovf});
         q0.delete();
         if (mode == 1) begin
            ioctl_download = 1'b1;
         end else begin
            #2;
            reset = 1'b1;
            #1;
            chk(f_mem_we == 1'b0, "async_reset_clears_we", f_mem_we, 0);
            power_on();
         end
      end
   endtask

   task automatic load_random(input int count);
      sa.delete();
      sd.delete();
      for (int i = 0; i < count; i++) begin
         if ($urandom_range(0, 9) == 0) sa.push_back(int'($urandom_range(c_DEPTH, 27'h7FF_FFFF)));
         else sa.push_back(int'($urandom_range(0, c_DEPTH - 1)));
         sd.push_back(int'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      exp_done[0] = 0;
      exp_done[1] = 0;
      #2 reset = 1'b1;
      power_on();

      sa.delete(); sd.delete();
      for (int i = 0; i < 16; i++) begin sa.push_back(i); sd.push_back(8'hA0 + i); end
      run_seq(0, 0, 1'b1, 1'b0, 1'b1);

      sa = '{4094, 4095, 4096, 27'h100000};
      sd = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_seq(0, 0, 1'b1, 1'b0, 1'b0);

      sa = '{100, 5, 300};
      sd = '{8'h5A, 8'hC3, 8'h7E};
      run_seq(0, 0, 1'b1, 1'b0, 1'b0);

      load_random(6);
      for (int i = 0; i < sa.size(); i++) sa[i] = sa[i] % 64;
      sa.push_back(27'h4000);
      sd.push_back(8'hEE);
      run_seq(1, 2000, 1'b1, 1'b0, 1'b0);
      load_random(8);
      run_seq(0, 0, 1'b1, 1'b0, 1'b0);

      sa = '{7};
      sd = '{int'($urandom_range(0, 255))};
      run_seq(2, 100, 1'b0, 1'b1, 1'b0);

      for (int r = 0; r < 3; r++) begin
         load_random(int'($urandom_range(1, 12)));
         run_seq(0, 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end

      repeat (20) @(negedge clk_sys);
      chk(exp_done[0] == 0 && exp_done[1] == 0, "no_done_outstanding", exp_done[0] + exp_done[1], 0);
      chk(!f_cpu_reset && !n_cpu_reset, "cpu_released_at_end", {f_cpu_reset, n_cpu_reset}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
